knn_driver: RTL and testbench

KNN_DRIVER -- requirements
Module: knn_driver

---
 rtl/knn_driver_pkg.sv | 29 ++
 rtl/knn_driver_if.sv | 26 ++
 rtl/knn_topk_insert.sv | 72 +++++++
 rtl/knn_driver.sv | 163 ++++++++++++++++
 tb/tb_knn_driver.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/knn_driver_pkg.sv
// Shared types and sizing for the KNN driver slice. The macro block carries the
// KNN_Header.vh definitions so every file sees the same data width, depth and timeout.
`ifndef KNN_HEADER_VH
`define KNN_HEADER_VH
`define WDATA_W       16
`define KNN_BUF_DEPTH 256
`define KNN_TIMEOUT   1024
`endif

package knn_driver_pkg;

    localparam int WDATA_W         = `WDATA_W;
    localparam int BUF_DEPTH       = `KNN_BUF_DEPTH;
    localparam int DEFAULT_TIMEOUT = `KNN_TIMEOUT;
    localparam int ADDR_W          = 8;
    localparam int NUM_W           = 9;
    localparam int RANK_W          = 3;
    localparam int MAX_RANKS       = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ISSUE,
        WAIT,
        INSERT,
        FINISH
    } drv_state_t;

endpackage

// File: rtl/knn_driver_if.sv
// Core-side bus between the KNN driver (master) and the distance core (slave).
interface knn_driver_if;
    import knn_driver_pkg::*;

    logic               KNN_START_O;
    logic [WDATA_W-1:0] KNN_DATA_PT_O;
    logic [WDATA_W-1:0] KNN_TEST_PT_O;
    logic               KNN_VALID_O;
    logic               KNN_SAMPLE_O;
    logic [ADDR_W-1:0]  KNN_ADDRESS_O;
    logic [WDATA_W-1:0] KNN_ADD_I;
    logic               KNN_VALID_I;

    modport master (
        output KNN_START_O, KNN_DATA_PT_O, KNN_TEST_PT_O,
               KNN_VALID_O, KNN_SAMPLE_O, KNN_ADDRESS_O,
        input  KNN_ADD_I, KNN_VALID_I
    );

    modport slave (
        input  KNN_START_O, KNN_DATA_PT_O, KNN_TEST_PT_O,
               KNN_VALID_O, KNN_SAMPLE_O, KNN_ADDRESS_O,
        output KNN_ADD_I, KNN_VALID_I
    );

endinterface

// File: rtl/knn_topk_insert.sv
// Ascending K-entry list of (distance, index) pairs with single-cycle sorted insert
// and a combinational rank read port.
module knn_topk_insert
    import knn_driver_pkg::*;
#(
    parameter int K = 4
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               clear,
    input  logic               insert,
    input  logic [WDATA_W-1:0] ins_dist,
    input  logic [ADDR_W-1:0]  ins_idx,
    input  logic [RANK_W-1:0]  rd_rank,
    output logic [WDATA_W-1:0] rd_dist,
    output logic [ADDR_W-1:0]  rd_index
);

    logic [WDATA_W-1:0] dist_reg  [K];
    logic [ADDR_W-1:0]  idx_reg   [K];
    logic [WDATA_W-1:0] dist_next [K];
    logic [ADDR_W-1:0]  idx_next  [K];
    logic [K-1:0]       less;

    logic [WDATA_W-1:0] rd_tab_dist [MAX_RANKS];
    logic [ADDR_W-1:0]  rd_tab_idx  [MAX_RANKS];

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_entry
            // Strict compare: an equal distance lands behind existing entries.
            assign less[gi] = ins_dist < dist_reg[gi];

            if (gi == 0) begin : g_head
                assign dist_next[gi] = less[gi] ? ins_dist : dist_reg[gi];
                assign idx_next[gi]  = less[gi] ? ins_idx  : idx_reg[gi];
            end else begin : g_tail
                // less[] is monotone over a sorted list, so the first set bit is
                // the slot; entries after it take their predecessor's value.
                assign dist_next[gi] = !less[gi]    ? dist_reg[gi]   :
                                       less[gi-1]   ? dist_reg[gi-1] : ins_dist;
                assign idx_next[gi]  = !less[gi]    ? idx_reg[gi]    :
                                       less[gi-1]   ? idx_reg[gi-1]  : ins_idx;
            end

            always_ff @(posedge clk) begin
                if (srst || clear) begin
                    dist_reg[gi] <= '1;
                    idx_reg[gi]  <= '1;
                end else if (insert) begin
                    dist_reg[gi] <= dist_next[gi];
                    idx_reg[gi]  <= idx_next[gi];
                end
            end
        end

        // Ranks beyond K read back as empty slots.
        for (gi = 0; gi < MAX_RANKS; gi++) begin : g_rd
            if (gi < K) begin : g_live
                assign rd_tab_dist[gi] = dist_reg[gi];
                assign rd_tab_idx[gi]  = idx_reg[gi];
            end else begin : g_empty
                assign rd_tab_dist[gi] = '1;
                assign rd_tab_idx[gi]  = '1;
            end
        end
    endgenerate

    assign rd_dist  = rd_tab_dist[rd_rank];
    assign rd_index = rd_tab_idx[rd_rank];

endmodule

// File: rtl/knn_driver.sv
// Host-facing KNN run controller: buffers data points, feeds them one at a time to
// the distance core, and keeps the K nearest results.
module knn_driver
    import knn_driver_pkg::*;
#(
    parameter int K       = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk_top,
    input  logic               rst_top,
    input  logic               DRV_WR_EN,
    input  logic [ADDR_W-1:0]  DRV_WR_ADDR,
    input  logic [WDATA_W-1:0] DRV_WR_DATA,
    input  logic [WDATA_W-1:0] DRV_TEST_PT,
    input  logic [NUM_W-1:0]   DRV_NUM_PTS,
    input  logic               DRV_GO,
    input  logic [RANK_W-1:0]  DRV_RD_IDX,
    output logic               DRV_BUSY,
    output logic               DRV_DONE,
    output logic               DRV_ERR,
    output logic [WDATA_W-1:0] DRV_NN_DIST,
    output logic [ADDR_W-1:0]  DRV_NN_IDX,
    knn_driver_if.master       core
);

    localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    drv_state_t         state_reg,    state_next;
    logic [ADDR_W-1:0]  counter_reg,  counter_next;
    logic [NUM_W-1:0]   num_pts_reg,  num_pts_next;
    logic [WDATA_W-1:0] test_pt_reg,  test_pt_next;
    logic [WDATA_W-1:0] dist_reg,     dist_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               err_reg,      err_next;
    logic               list_clear;
    logic               list_insert;
    logic               num_ok;

    logic [WDATA_W-1:0] buf_mem [BUF_DEPTH];
    logic [WDATA_W-1:0] rd_data_reg;

    assign num_ok = (DRV_NUM_PTS != '0) && (DRV_NUM_PTS <= NUM_W'(BUF_DEPTH));

    always_ff @(posedge clk_top) begin
        if (rst_top) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            num_pts_reg  <= '0;
            test_pt_reg  <= '0;
            dist_reg     <= '0;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            num_pts_reg  <= num_pts_next;
            test_pt_reg  <= test_pt_next;
            dist_reg     <= dist_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        num_pts_next  = num_pts_reg;
        test_pt_next  = test_pt_reg;
        dist_next     = dist_reg;
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;
        list_clear    = 1'b0;
        list_insert   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (DRV_GO) begin
                    if (num_ok) begin
                        num_pts_next = DRV_NUM_PTS;
                        test_pt_next = DRV_TEST_PT;
                        state_next   = START;
                    end else begin
                        // Degenerate run: empty result, no core traffic.
                        list_clear = 1'b1;
                        state_next = FINISH;
                    end
                end
            end
            START: begin
                list_clear   = 1'b1;
                counter_next = '0;
                err_next     = 1'b0;
                state_next   = ISSUE;
            end
            ISSUE: begin
                wait_cnt_next = '0;
                state_next    = WAIT;
            end
            WAIT: begin
                if (core.KNN_VALID_I) begin
                    dist_next  = core.KNN_ADD_I;
                    state_next = INSERT;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    err_next   = 1'b1;
                    state_next = FINISH;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            INSERT: begin
                list_insert  = 1'b1;
                counter_next = counter_reg + 1'b1;
                if ({1'b0, counter_reg} == num_pts_reg - 1'b1) begin
                    state_next = FINISH;
                end else begin
                    state_next = ISSUE;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read address follows counter_next so rd_data_reg always matches counter_reg,
    // which puts the right point on the bus in the ISSUE cycle.
    always_ff @(posedge clk_top) begin
        if (DRV_WR_EN && (state_reg == IDLE)) begin
            buf_mem[DRV_WR_ADDR] <= DRV_WR_DATA;
        end
        rd_data_reg <= buf_mem[counter_next];
    end

    knn_topk_insert #(
        .K (K)
    ) u_topk (
        .clk      (clk_top),
        .srst     (rst_top),
        .clear    (list_clear),
        .insert   (list_insert),
        .ins_dist (dist_reg),
        .ins_idx  (counter_reg),
        .rd_rank  (DRV_RD_IDX),
        .rd_dist  (DRV_NN_DIST),
        .rd_index (DRV_NN_IDX)
    );

    assign core.KNN_START_O   = (state_reg == START);
    assign core.KNN_VALID_O   = (state_reg == ISSUE);
    assign core.KNN_SAMPLE_O  = (state_reg == ISSUE);
    assign core.KNN_ADDRESS_O = counter_reg;
    assign core.KNN_DATA_PT_O = (state_reg == ISSUE) ? rd_data_reg : '0;
    assign core.KNN_TEST_PT_O = test_pt_reg;

    assign DRV_BUSY = (state_reg != IDLE);
    assign DRV_DONE = (state_reg == FINISH);
    assign DRV_ERR  = err_reg;

endmodule

// File: tb/tb_knn_driver.sv
// Directed bench for knn_driver: a small core model echoes each data point as its
// distance three cycles after issue, optionally never answering one address.
module tb_knn_driver;
    import knn_driver_pkg::*;

    localparam int W = WDATA_W;
    localparam logic [W-1:0] ONES = '1;

    logic               clk_top = 1'b0;
    logic               rst_top;
    logic               DRV_WR_EN;
    logic [7:0]         DRV_WR_ADDR;
    logic [W-1:0]       DRV_WR_DATA;
    logic [W-1:0]       DRV_TEST_PT;
    logic [8:0]         DRV_NUM_PTS;
    logic               DRV_GO;
    logic [2:0]         DRV_RD_IDX;
    logic               DRV_BUSY, DRV_DONE, DRV_ERR;
    logic [W-1:0]       DRV_NN_DIST;
    logic [7:0]         DRV_NN_IDX;

    knn_driver_if core_bus ();

    knn_driver #(.K(4), .TIMEOUT(1024)) dut (
        .clk_top     (clk_top),
        .rst_top     (rst_top),
        .DRV_WR_EN   (DRV_WR_EN),
        .DRV_WR_ADDR (DRV_WR_ADDR),
        .DRV_WR_DATA (DRV_WR_DATA),
        .DRV_TEST_PT (DRV_TEST_PT),
        .DRV_NUM_PTS (DRV_NUM_PTS),
        .DRV_GO      (DRV_GO),
        .DRV_RD_IDX  (DRV_RD_IDX),
        .DRV_BUSY    (DRV_BUSY),
        .DRV_DONE    (DRV_DONE),
        .DRV_ERR     (DRV_ERR),
        .DRV_NN_DIST (DRV_NN_DIST),
        .DRV_NN_IDX  (DRV_NN_IDX),
        .core        (core_bus)
    );

    always #5 clk_top = ~clk_top;

    int n_cmp = 0;
    int n_bad = 0;

    // Core model state
    logic         model_valid = 1'b0;
    logic [W-1:0] model_add   = '0;
    logic         spur_valid  = 1'b0;
    logic         drop_en     = 1'b0;
    logic [7:0]   drop_addr   = 8'd0;
    logic         pend        = 1'b0;
    int           dly         = 0;
    logic [W-1:0] pend_data   = '0;
    int           valid_cnt   = 0;
    int           issue_hits [256];
    int           done_cnt    = 0;
    int           busy_cnt    = 0;

    assign core_bus.KNN_VALID_I = model_valid | spur_valid;
    assign core_bus.KNN_ADD_I   = model_valid ? model_add : '0;

    initial for (int i = 0; i < 256; i++) issue_hits[i] = 0;

    always @(negedge clk_top) begin
        if (rst_top) begin
            model_valid = 1'b0;
            pend        = 1'b0;
        end else begin
            if (model_valid) model_valid = 1'b0;
            if (pend) begin
                dly = dly - 1;
                if (dly == 0) begin
                    model_valid = 1'b1;
                    model_add   = pend_data;
                    pend        = 1'b0;
                end
            end
            if (core_bus.KNN_VALID_O && core_bus.KNN_SAMPLE_O) begin
                valid_cnt = valid_cnt + 1;
                issue_hits[core_bus.KNN_ADDRESS_O] = issue_hits[core_bus.KNN_ADDRESS_O] + 1;
                if (!(drop_en && core_bus.KNN_ADDRESS_O == drop_addr)) begin
                    pend      = 1'b1;
                    dly       = 3;
                    pend_data = core_bus.KNN_DATA_PT_O;
                end
            end
        end
    end

    always @(negedge clk_top) begin
        if (DRV_DONE) done_cnt = done_cnt + 1;
        if (DRV_BUSY) busy_cnt = busy_cnt + 1;
    end

    task automatic write_pt(input logic [7:0] addr, input logic [W-1:0] data);
        @(negedge clk_top);
        DRV_WR_EN   = 1'b1;
        DRV_WR_ADDR = addr;
        DRV_WR_DATA = data;
        @(negedge clk_top);
        DRV_WR_EN   = 1'b0;
    endtask

    task automatic start_run(input logic [W-1:0] tp, input logic [8:0] n);
        @(negedge clk_top);
        DRV_TEST_PT = tp;
        DRV_NUM_PTS = n;
        DRV_GO      = 1'b1;
        @(negedge clk_top);
        DRV_GO      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (DRV_DONE) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_top);
        end
        repeat (3) @(negedge clk_top);
    endtask

    task automatic test_reset();
        rst_top = 1'b1;
        repeat (3) @(posedge clk_top);
        @(negedge clk_top);
        DRV_RD_IDX = 3'd0;
        #1;
        n_cmp++;
        if ({DRV_BUSY, DRV_DONE, DRV_ERR, core_bus.KNN_START_O, core_bus.KNN_VALID_O,
             core_bus.KNN_SAMPLE_O} !== 6'b0) begin
            $display("FAIL reset_flags: got %b want 000000", {DRV_BUSY, DRV_DONE, DRV_ERR,
                     core_bus.KNN_START_O, core_bus.KNN_VALID_O, core_bus.KNN_SAMPLE_O});
            n_bad++;
        end
        n_cmp++;
        if ({core_bus.KNN_ADDRESS_O, core_bus.KNN_DATA_PT_O, core_bus.KNN_TEST_PT_O} !== '0) begin
            $display("FAIL reset_bus: got addr %0d data %0d test %0d want 0 0 0",
                     core_bus.KNN_ADDRESS_O, core_bus.KNN_DATA_PT_O, core_bus.KNN_TEST_PT_O);
            n_bad++;
        end
        n_cmp++;
        if (DRV_NN_DIST !== ONES || DRV_NN_IDX !== 8'hFF) begin
            $display("FAIL reset_list: got %0h/%0h want ffff/ff", DRV_NN_DIST, DRV_NN_IDX);
            n_bad++;
        end
        rst_top = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int exp_d[5] = '{10, 20, 30, 40, 65535};
        int exp_i[5] = '{1, 3, 2, 0, 255};
        int d0, b0, v0;
        bit ok;
        write_pt(8'd0, 16'd40);
        write_pt(8'd1, 16'd10);
        write_pt(8'd2, 16'd30);
        write_pt(8'd3, 16'd20);
        d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
        start_run(16'd7, 9'd4);
        n_cmp++;
        if (core_bus.KNN_TEST_PT_O !== 16'd7) begin
            $display("FAIL basic_test_pt: got %0d want 7", core_bus.KNN_TEST_PT_O);
            n_bad++;
        end
        wait_done(200, ok);
        n_cmp++;
        if (!ok) begin
            $display("FAIL basic_timeout: got no DONE want DONE within 200 cycles");
            n_bad++;
        end
        for (int r = 0; r < 5; r++) begin
            DRV_RD_IDX = 3'(r);
            #1;
            n_cmp++;
            if (DRV_NN_DIST !== exp_d[r] || DRV_NN_IDX !== exp_i[r]) begin
                $display("FAIL basic_rank%0d: got %0d/%0d want %0d/%0d", r, DRV_NN_DIST,
                         DRV_NN_IDX, exp_d[r], exp_i[r]);
                n_bad++;
            end
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
            n_bad++;
        end
        n_cmp++;
        if (busy_cnt - b0 != 22) begin
            $display("FAIL basic_busy_cycles: got %0d want 22", busy_cnt - b0);
            n_bad++;
        end
        n_cmp++;
        if (valid_cnt - v0 != 4 || DRV_ERR !== 1'b0) begin
            $display("FAIL basic_issues_err: got %0d/%b want 4/0", valid_cnt - v0, DRV_ERR);
            n_bad++;
        end
        $display("test_basic: done");
    endtask

    task automatic test_ties();
        bit ok;
        for (int i = 0; i < 5; i++) write_pt(8'(i), 16'd5);
        start_run(16'd0, 9'd5);
        wait_done(200, ok);
        n_cmp++;
        if (!ok) begin
            $display("FAIL ties_timeout: got no DONE want DONE within 200 cycles");
            n_bad++;
        end
        for (int r = 0; r < 4; r++) begin
            DRV_RD_IDX = 3'(r);
            #1;
            n_cmp++;
            if (DRV_NN_DIST !== 16'd5 || DRV_NN_IDX !== 8'(r)) begin
                $display("FAIL ties_rank%0d: got %0d/%0d want 5/%0d", r, DRV_NN_DIST,
                         DRV_NN_IDX, r);
                n_bad++;
            end
        end
        // A result strobe while idle must not touch the list.
        @(negedge clk_top);
        spur_valid = 1'b1;
        @(negedge clk_top);
        spur_valid = 1'b0;
        repeat (2) @(negedge clk_top);
        DRV_RD_IDX = 3'd0;
        #1;
        n_cmp++;
        if (DRV_NN_DIST !== 16'd5 || DRV_NN_IDX !== 8'd0) begin
            $display("FAIL idle_valid_ignored: got %0d/%0d want 5/0", DRV_NN_DIST, DRV_NN_IDX);
            n_bad++;
        end
        $display("test_ties: done");
    endtask

    task automatic test_bad_count();
        logic [8:0] nums[2] = '{9'd0, 9'd300};
        int v0;
        for (int k = 0; k < 2; k++) begin
            v0 = valid_cnt;
            @(negedge clk_top);
            DRV_NUM_PTS = nums[k];
            DRV_GO      = 1'b1;
            @(negedge clk_top);
            DRV_GO      = 1'b0;
            n_cmp++;
            if (DRV_DONE !== 1'b1) begin
                $display("FAIL badnum%0d_done: got %b want 1", nums[k], DRV_DONE);
                n_bad++;
            end
            @(negedge clk_top);
            DRV_RD_IDX = 3'd0;
            #1;
            n_cmp++;
            if (DRV_DONE !== 1'b0 || DRV_BUSY !== 1'b0 || DRV_NN_DIST !== ONES ||
                DRV_NN_IDX !== 8'hFF) begin
                $display("FAIL badnum%0d_after: got done %b busy %b list %0h/%0h want 0 0 ffff/ff",
                         nums[k], DRV_DONE, DRV_BUSY, DRV_NN_DIST, DRV_NN_IDX);
                n_bad++;
            end
            repeat (3) @(negedge clk_top);
            n_cmp++;
            if (valid_cnt != v0) begin
                $display("FAIL badnum%0d_no_issue: got %0d issues want 0", nums[k], valid_cnt - v0);
                n_bad++;
            end
        end
        $display("test_bad_count: done");
    endtask

    task automatic test_full_buffer();
        int hits0 [256];
        int bad_addr;
        bit ok;
        for (int i = 0; i < 256; i++) write_pt(8'(i), 16'(255 - i));
        for (int i = 0; i < 256; i++) hits0[i] = issue_hits[i];
        start_run(16'd0, 9'd256);
        wait_done(3000, ok);
        n_cmp++;
        if (!ok) begin
            $display("FAIL full_timeout: got no DONE want DONE within 3000 cycles");
            n_bad++;
        end
        bad_addr = 0;
        for (int i = 0; i < 256; i++) if (issue_hits[i] - hits0[i] != 1) bad_addr++;
        n_cmp++;
        if (bad_addr != 0) begin
            $display("FAIL full_addresses: got %0d addresses not issued exactly once want 0",
                     bad_addr);
            n_bad++;
        end
        for (int r = 0; r < 4; r++) begin
            DRV_RD_IDX = 3'(r);
            #1;
            n_cmp++;
            if (DRV_NN_DIST !== 16'(r) || DRV_NN_IDX !== 8'(255 - r)) begin
                $display("FAIL full_rank%0d: got %0d/%0d want %0d/%0d", r, DRV_NN_DIST,
                         DRV_NN_IDX, r, 255 - r);
                n_bad++;
            end
        end
        $display("test_full_buffer: done");
    endtask

    task automatic test_timeout();
        int d0, b0;
        bit ok;
        write_pt(8'd0, 16'd7);
        write_pt(8'd1, 16'd3);
        write_pt(8'd2, 16'd9);
        write_pt(8'd3, 16'd1);
        drop_en   = 1'b1;
        drop_addr = 8'd2;
        d0 = done_cnt; b0 = busy_cnt;
        start_run(16'd0, 9'd4);
        wait_done(3000, ok);
        drop_en = 1'b0;
        n_cmp++;
        if (!ok || DRV_ERR !== 1'b1) begin
            $display("FAIL timeout_err: got done %b err %b want 1 1", ok, DRV_ERR);
            n_bad++;
        end
        n_cmp++;
        if (busy_cnt - b0 != 1037 || done_cnt - d0 != 1) begin
            $display("FAIL timeout_length: got busy %0d done %0d want 1037 1",
                     busy_cnt - b0, done_cnt - d0);
            n_bad++;
        end
        for (int r = 0; r < 3; r++) begin
            int ed = (r == 0) ? 3 : (r == 1) ? 7 : 65535;
            int ei = (r == 0) ? 1 : (r == 1) ? 0 : 255;
            DRV_RD_IDX = 3'(r);
            #1;
            n_cmp++;
            if (DRV_NN_DIST !== ed || DRV_NN_IDX !== ei) begin
                $display("FAIL timeout_rank%0d: got %0d/%0d want %0d/%0d", r, DRV_NN_DIST,
                         DRV_NN_IDX, ed, ei);
                n_bad++;
            end
        end
        $display("test_timeout: done");
    endtask

    task automatic test_reset_midrun();
        int d0;
        bit found, ok;
        for (int i = 0; i < 8; i++) write_pt(8'(i), 16'(100 + i));
        start_run(16'h1234, 9'd8);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_top);
            if (core_bus.KNN_VALID_O && core_bus.KNN_ADDRESS_O == 8'd5) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            $display("FAIL midrun_reach: got no issue of point 5 want issue within 200 cycles");
            n_bad++;
        end
        @(negedge clk_top);
        d0 = done_cnt;
        rst_top = 1'b1;
        @(posedge clk_top);
        #1;
        DRV_RD_IDX = 3'd0;
        #1;
        n_cmp++;
        if ({DRV_BUSY, DRV_DONE, DRV_ERR, core_bus.KNN_START_O, core_bus.KNN_VALID_O,
             core_bus.KNN_SAMPLE_O} !== 6'b0 || core_bus.KNN_ADDRESS_O !== 8'd0 ||
            core_bus.KNN_TEST_PT_O !== '0 || core_bus.KNN_DATA_PT_O !== '0) begin
            $display("FAIL midrun_outputs: got busy %b addr %0d test %0h want 0 0 0",
                     DRV_BUSY, core_bus.KNN_ADDRESS_O, core_bus.KNN_TEST_PT_O);
            n_bad++;
        end
        n_cmp++;
        if (DRV_NN_DIST !== ONES || DRV_NN_IDX !== 8'hFF) begin
            $display("FAIL midrun_list: got %0h/%0h want ffff/ff", DRV_NN_DIST, DRV_NN_IDX);
            n_bad++;
        end
        @(negedge clk_top);
        @(negedge clk_top);
        rst_top = 1'b0;
        repeat (6) @(negedge clk_top);
        n_cmp++;
        if (done_cnt != d0) begin
            $display("FAIL midrun_no_done: got %0d DONE pulses want 0", done_cnt - d0);
            n_bad++;
        end
        // Clean run afterwards
        write_pt(8'd0, 16'd8);
        write_pt(8'd1, 16'd6);
        write_pt(8'd2, 16'd7);
        write_pt(8'd3, 16'd5);
        d0 = done_cnt;
        start_run(16'd1, 9'd4);
        wait_done(200, ok);
        n_cmp++;
        if (!ok || done_cnt - d0 != 1 || DRV_ERR !== 1'b0) begin
            $display("FAIL rerun_done: got ok %b done %0d err %b want 1 1 0", ok,
                     done_cnt - d0, DRV_ERR);
            n_bad++;
        end
        for (int r = 0; r < 4; r++) begin
            int ed = 5 + r;
            int ei = (r == 0) ? 3 : (r == 1) ? 1 : (r == 2) ? 2 : 0;
            DRV_RD_IDX = 3'(r);
            #1;
            n_cmp++;
            if (DRV_NN_DIST !== ed || DRV_NN_IDX !== ei) begin
                $display("FAIL rerun_rank%0d: got %0d/%0d want %0d/%0d", r, DRV_NN_DIST,
                         DRV_NN_IDX, ed, ei);
                n_bad++;
            end
        end
        $display("test_reset_midrun: done");
    endtask

    initial begin
        rst_top     = 1'b1;
        DRV_WR_EN   = 1'b0;
        DRV_WR_ADDR = '0;
        DRV_WR_DATA = '0;
        DRV_TEST_PT = '0;
        DRV_NUM_PTS = '0;
        DRV_GO      = 1'b0;
        DRV_RD_IDX  = '0;
        test_reset();
        test_basic();
        test_ties();
        test_bad_count();
        test_full_buffer();
        test_timeout();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
